// File: rtl/async_fifo1_wr_arbiter.sv
// Round-robin write-port arbiter sharing one async_fifo1 write port between NREQ valid/ready requesters.
// Optional ARB_BURST_EN macro locks each grant for up to BURST_LEN words.
module async_fifo1_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [GW-1:0]         grant_id,
  output logic                  busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   grant_id_q;
`ifdef ARB_BURST_EN
  logic [7:0]      burst_cnt_q;
`endif

  logic            srch_found;
  logic [GW-1:0]   srch_win;
  logic            found;
  logic [GW-1:0]   win;
  logic            xfer;

  function automatic logic [GW-1:0] inc_mod(input logic [GW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    srch_found = 1'b0;
    srch_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!srch_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        srch_found = 1'b1;
        srch_win   = GW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // A nonzero burst count means the grant is locked to grant_id_q.
  always_comb begin
    found = srch_found;
    win   = srch_win;
`ifdef ARB_BURST_EN
    if (burst_cnt_q != 8'd0) begin
      found = req_valid[grant_id_q];
      win   = grant_id_q;
    end
`endif
  end

  // Reset gates the combinational handshake so nothing is written or acknowledged during reset.
  assign xfer      = wrst_n & found & ~wfull;
  assign winc      = xfer;
  assign req_ready = xfer ? (NREQ'(1) << win) : '0;
  assign wdata     = req_data[win*DSIZE +: DSIZE];
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == GRANT);

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
`ifdef ARB_BURST_EN
      burst_cnt_q <= 8'd0;
`endif
    end else if (!wfull) begin
      if (xfer) grant_id_q <= win;

      case (state_q)
        IDLE:    if (xfer) state_q <= GRANT;
        GRANT:   if (req_valid == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

`ifdef ARB_BURST_EN
      if (burst_cnt_q != 8'd0 && !req_valid[grant_id_q]) begin
        burst_cnt_q <= 8'd0;
        ptr_q       <= inc_mod(grant_id_q);
      end else if (xfer) begin
        if ((burst_cnt_q + 8'd1) == 8'(BURST_LEN)) begin
          burst_cnt_q <= 8'd0;
          ptr_q       <= inc_mod(win);
        end else begin
          burst_cnt_q <= burst_cnt_q + 8'd1;
        end
      end
`else
      if (xfer) ptr_q <= inc_mod(win);
`endif
    end
  end

endmodule

// File: tb/tb_async_fifo1_wr_arbiter.sv
// Table-driven bench for async_fifo1_wr_arbiter; expected words go through a scoreboard queue
// and are compared against a FIFO capture model. Burst rows are used when ARB_BURST_EN is defined.
module tb_async_fifo1_wr_arbiter;

  localparam int DSIZE = 8;
  localparam int NREQ  = 4;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            grant_id;
  logic                  busy;

  async_fifo1_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_LEN(4)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    logic       full;
    logic [3:0] ready;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t            vecs[$];
  logic [7:0]      exp_q[$];
  logic [7:0]      exp_log[$];
  logic [7:0]      fifo_q[$];
  logic [5:0]      seq [NREQ] = '{default: 6'd0};
  int              n_checks = 0;
  int              n_pass   = 0;

  // Requester model: advance the word index on each acknowledged word.
  always @(posedge wclk) begin
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) seq[i] <= seq[i] + 6'd1;
  end

  // FIFO model: capture whatever is written.
  always @(posedge wclk) begin
    if (winc) fifo_q.push_back(wdata);
  end

  function automatic logic [7:0] word(input int i);
    logic [1:0] id;
    id = 2'(i);
    return {id, seq[i]};
  endfunction

  function automatic int onehot_id(input logic [3:0] oh);
    int id;
    id = 0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) id = i;
    return id;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic [3:0] mask, input logic full,
                     input logic [3:0] ready, input logic [1:0] gid, input logic b);
    vec_t v;
    v.rst = rst; v.mask = mask; v.full = full; v.ready = ready; v.gid = gid; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int row);
    logic [7:0] w;
    @(negedge wclk);
    wrst_n    = !v.rst;
    req_valid = v.mask;
    wfull     = v.full;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = word(i);
    if (v.ready != 4'd0) begin
      w = word(onehot_id(v.ready));
      exp_q.push_back(w);
      exp_log.push_back(w);
    end
    #1;
    check($sformatf("row%0d ready", row), 32'(req_ready), 32'(v.ready));
    check($sformatf("row%0d winc", row), 32'(winc), 32'(v.ready != 4'd0));
    check($sformatf("row%0d grant_id", row), 32'(grant_id), 32'(v.gid));
    check($sformatf("row%0d busy", row), 32'(busy), 32'(v.busy));
    if (winc) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL row%0d sb_unexpected: got word %0h expected none", row, wdata);
      end else begin
        w = exp_q.pop_front();
        if (wdata === w) n_pass++;
        else $display("FAIL row%0d wdata: got %0h expected %0h", row, wdata, w);
      end
    end
  endtask

  initial begin
    // Reset hold: every requester valid while reset is low.
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    #1;
    check("reset winc", 32'(winc), 32'd0);
    check("reset ready", 32'(req_ready), 32'd0);
    check("reset grant_id", 32'(grant_id), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (2) @(posedge wclk);
    #1;
    check("reset hold winc", 32'(winc), 32'd0);
    check("reset hold ready", 32'(req_ready), 32'd0);

`ifdef ARB_BURST_EN
    // rst, mask, full, ready, gid, busy
    add(0, 4'hF, 0, 4'h1, 2'd0, 0);
    add(0, 4'hF, 0, 4'h1, 2'd0, 1);
    add(0, 4'hF, 0, 4'h1, 2'd0, 1);
    add(0, 4'hF, 0, 4'h1, 2'd0, 1);
    add(0, 4'hF, 0, 4'h2, 2'd0, 1);
    add(0, 4'hF, 0, 4'h2, 2'd1, 1);
    add(0, 4'hD, 0, 4'h0, 2'd1, 1);  // locked requester 1 drops valid
    add(0, 4'hD, 0, 4'h4, 2'd1, 1);
    add(0, 4'hD, 1, 4'h0, 2'd2, 1);  // full mid-burst
    add(0, 4'hD, 0, 4'h4, 2'd2, 1);
    add(0, 4'hD, 0, 4'h4, 2'd2, 1);
    add(0, 4'hD, 0, 4'h4, 2'd2, 1);
    add(0, 4'hD, 0, 4'h8, 2'd2, 1);
    add(1, 4'hD, 0, 4'h0, 2'd0, 0);  // reset mid-burst
    add(0, 4'h6, 0, 4'h2, 2'd0, 0);
    add(0, 4'h6, 0, 4'h2, 2'd1, 1);
    add(0, 4'h6, 0, 4'h2, 2'd1, 1);
`else
    add(0, 4'hF, 0, 4'h1, 2'd0, 0);
    add(0, 4'hF, 0, 4'h2, 2'd0, 1);
    add(0, 4'hF, 0, 4'h4, 2'd1, 1);
    add(0, 4'hF, 0, 4'h8, 2'd2, 1);
    add(0, 4'hF, 0, 4'h1, 2'd3, 1);
    add(0, 4'hF, 0, 4'h2, 2'd0, 1);
    add(0, 4'hF, 0, 4'h4, 2'd1, 1);
    add(0, 4'hF, 0, 4'h8, 2'd2, 1);
    add(0, 4'hA, 0, 4'h2, 2'd3, 1);  // sparse: only 1 and 3
    add(0, 4'hA, 0, 4'h8, 2'd1, 1);
    add(0, 4'hA, 0, 4'h2, 2'd3, 1);
    add(0, 4'hA, 0, 4'h8, 2'd1, 1);
    add(0, 4'hF, 0, 4'h1, 2'd3, 1);
    add(0, 4'hF, 0, 4'h2, 2'd0, 1);
    add(0, 4'hF, 0, 4'h4, 2'd1, 1);
    add(0, 4'hF, 1, 4'h0, 2'd2, 1);  // full stall after grant to 2
    add(0, 4'hF, 1, 4'h0, 2'd2, 1);
    add(0, 4'hF, 0, 4'h8, 2'd2, 1);
    add(0, 4'hF, 0, 4'h1, 2'd3, 1);
    add(0, 4'h0, 0, 4'h0, 2'd0, 1);
    add(0, 4'h0, 0, 4'h0, 2'd0, 0);
    add(0, 4'h8, 1, 4'h0, 2'd0, 0);  // full while idle
    add(0, 4'h1, 0, 4'h1, 2'd0, 0);  // search from 1 wraps to 0
    add(0, 4'hF, 0, 4'h2, 2'd0, 1);
    add(1, 4'hF, 0, 4'h0, 2'd0, 0);  // reset mid-stream
    add(0, 4'h6, 0, 4'h2, 2'd0, 0);
    add(0, 4'h6, 0, 4'h4, 2'd1, 1);
`endif

    for (int r = 0; r < vecs.size(); r++) apply(vecs[r], r);

    @(negedge wclk);
    req_valid = 4'h0;
    @(negedge wclk);

    check("sb drained", 32'(exp_q.size()), 32'd0);
    check("fifo word count", 32'(fifo_q.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < fifo_q.size(); i++)
      check($sformatf("fifo word %0d", i), 32'(fifo_q[i]), 32'(exp_log[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
